// File: rtl/ram8_arbiter_pkg.sv
// Shared definitions for the two-requester 8-word RAM arbiter:
// FSM state encodings, requester IDs and default port widths.
package ram8_arbiter_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t DONE   = 2'd2;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Two-way grant picker. A lone request always wins; on a tie the
// requester that was not served last wins.
module arb_pick2
  import ram8_arbiter_pkg::*;
(
  input  logic reqA,
  input  logic reqB,
  input  logic last,
  output logic winner
);

  // tie -> the other one than last; otherwise whoever is asking
  always_comb begin
    winner = REQ_A;
    if (reqA && reqB) winner = ~last;
    else if (reqB)    winner = REQ_B;
  end

endmodule

// File: rtl/ram8_arbiter.sv
// Arbiter sharing one 8-word register memory between requesters A and B.
// Each transaction is IDLE -> ACCESS -> DONE, one cycle per state.
// Optional macro RAM8_ARB_FIXED_PRIORITY_EN: A always wins a tie and no
// round-robin history is kept; undefined gives round-robin arbitration.
//
//   state  | meaning
//   IDLE   | waiting for a request; winner latched into gnt on entry to ACCESS
//   ACCESS | memory driven from granted requester; read data captured at end
//   DONE   | ack pulsed to granted requester; round-robin history updated
module ram8_arbiter
  import ram8_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              reqA,
  input  logic              reqB,
  input  logic              weA,
  input  logic              weB,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] dinA,
  input  logic [DATA_W-1:0] dinB,
  output logic              ackA,
  output logic              ackB,
  output logic [DATA_W-1:0] doutA,
  output logic [DATA_W-1:0] doutB,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  state_t state;
  logic   gnt;
  logic   last_sel;
  logic   winner;

`ifdef RAM8_ARB_FIXED_PRIORITY_EN
  // pretending B was served last makes every tie go to A
  assign last_sel = REQ_B;
`else
  logic last;

  // round-robin history: remember who completed most recently
  always_ff @(posedge clk) begin
    if (reset)              last <= REQ_B;
    else if (state == DONE) last <= gnt;
  end

  assign last_sel = last;
`endif

  arb_pick2 u_pick (
    .reqA   (reqA),
    .reqB   (reqB),
    .last   (last_sel),
    .winner (winner)
  );

  // transaction sequencer and grant latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= REQ_A;
    end else begin
      case (state)
        IDLE: begin
          if (reqA || reqB) begin
            gnt   <= winner;
            state <= ACCESS;
          end
        end
        ACCESS:  state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // capture memory read data for the granted requester; for a write this is
  // the word's old contents since the memory updates on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      doutA <= '0;
      doutB <= '0;
    end else if (state == ACCESS) begin
      if (gnt == REQ_A) doutA <= mem_out;
      else              doutB <= mem_out;
    end
  end

  // memory port: driven only in ACCESS, write blocked while reset is high
  always_comb begin
    mem_addr  = '0;
    mem_in    = '0;
    mem_write = 1'b0;
    if (state == ACCESS) begin
      mem_addr  = (gnt == REQ_B) ? addrB : addrA;
      mem_in    = (gnt == REQ_B) ? dinB  : dinA;
      mem_write = ((gnt == REQ_B) ? weB : weA) & ~reset;
    end
  end

  // acks and busy are decoded from state, silenced by reset in the same cycle
  always_comb begin
    ackA = (state == DONE) && (gnt == REQ_A) && !reset;
    ackB = (state == DONE) && (gnt == REQ_B) && !reset;
    busy = (state != IDLE) && !reset;
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter with an 8x16 register memory on mem_*.
module tb_ram8_arbiter;

  logic        clk;
  logic        reset;
  logic        reqA, reqB, weA, weB;
  logic [2:0]  addrA, addrB;
  logic [15:0] dinA, dinB;
  logic        ackA, ackB;
  logic [15:0] doutA, doutB;
  logic [15:0] mem_in;
  logic [2:0]  mem_addr;
  logic        mem_write;
  logic [15:0] mem_out;
  logic        busy;

  logic [15:0] mem [8];
  logic        mem_clr;

  int errors = 0;
  int checks = 0;

  ram8_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .reqA      (reqA),
    .reqB      (reqB),
    .weA       (weA),
    .weB       (weB),
    .addrA     (addrA),
    .addrB     (addrB),
    .dinA      (dinA),
    .dinB      (dinB),
    .ackA      (ackA),
    .ackB      (ackB),
    .doutA     (doutA),
    .doutB     (doutB),
    .mem_in    (mem_in),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_out   (mem_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the external 8-word memory: synchronous write, combinational read
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_in;
    end
  end
  assign mem_out = mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one uncontended transaction: request, ACCESS, DONE (ack), back to IDLE
  task automatic run_txn(input string tag, input logic isb, input logic we,
                         input logic [2:0] addr, input logic [15:0] din,
                         input logic [15:0] expd);
    if (isb) begin
      reqB = 1'b1; weB = we; addrB = addr; dinB = din;
    end else begin
      reqA = 1'b1; weA = we; addrA = addr; dinA = din;
    end
    tick();
    chk({tag, ".acc_we"},   {31'd0, mem_write}, {31'd0, we});
    chk({tag, ".acc_addr"}, {29'd0, mem_addr},  {29'd0, addr});
    chk({tag, ".acc_busy"}, {31'd0, busy},      32'd1);
    chk({tag, ".acc_noack"}, {30'd0, ackA, ackB}, 32'd0);
    tick();
    chk({tag, ".done_ack"}, {30'd0, ackA, ackB}, isb ? 32'd1 : 32'd2);
    chk({tag, ".done_dout"}, {16'd0, isb ? doutB : doutA}, {16'd0, expd});
    chk({tag, ".done_nowr"}, {31'd0, mem_write}, 32'd0);
    reqA = 1'b0;
    reqB = 1'b0;
    tick();
    chk({tag, ".idle_ack"},  {30'd0, ackA, ackB}, 32'd0);
    chk({tag, ".idle_busy"}, {31'd0, busy},       32'd0);
  endtask

  logic exp_order [4];

  initial begin
`ifdef RAM8_ARB_FIXED_PRIORITY_EN
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    reset = 1'b1; mem_clr = 1'b1;
    reqA = 1'b0; reqB = 1'b0; weA = 1'b0; weB = 1'b0;
    addrA = 3'd0; addrB = 3'd0; dinA = 16'h0; dinB = 16'h0;
    tick();
    tick();
    mem_clr = 1'b0;
    chk("rst.busy",  {31'd0, busy},       32'd0);
    chk("rst.acks",  {30'd0, ackA, ackB}, 32'd0);
    chk("rst.doutA", {16'd0, doutA},      32'd0);
    chk("rst.doutB", {16'd0, doutB},      32'd0);
    chk("rst.memwr", {31'd0, mem_write},  32'd0);
    chk("rst.maddr", {29'd0, mem_addr},   32'd0);
    chk("rst.min",   {16'd0, mem_in},     32'd0);
    reset = 1'b0;
    tick();

    // write A BEEF to 5, then read it back through B
    run_txn("wrA5", 1'b0, 1'b1, 3'd5, 16'hBEEF, 16'h0000);
    chk("wrA5.mem5", {16'd0, mem[5]}, 32'h0000BEEF);
    run_txn("rdB5", 1'b1, 1'b0, 3'd5, 16'h0000, 16'hBEEF);
    chk("rdB5.mem5", {16'd0, mem[5]}, 32'h0000BEEF);
    run_txn("holdB", 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    chk("holdB.doutB", {16'd0, doutB}, 32'h0000BEEF);

    // contention from reset: both held high, writes to 1 and 2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reqA = 1'b1; weA = 1'b1; addrA = 3'd1; dinA = 16'h1111;
    reqB = 1'b1; weB = 1'b1; addrB = 3'd2; dinB = 16'h2222;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("cont.ackA%0d", k), {31'd0, ackA},
          {31'd0, (k % 3 == 2) && (exp_order[k / 3] == 1'b0)});
      chk($sformatf("cont.ackB%0d", k), {31'd0, ackB},
          {31'd0, (k % 3 == 2) && (exp_order[k / 3] == 1'b1)});
    end
    reqA = 1'b0;
    reqB = 1'b0;
    tick();
    chk("cont.idle", {31'd0, busy}, 32'd0);
    chk("cont.mem1", {16'd0, mem[1]}, 32'h00001111);
`ifndef RAM8_ARB_FIXED_PRIORITY_EN
    chk("cont.mem2", {16'd0, mem[2]}, 32'h00002222);
`endif

    // reset during ACCESS of a write of 1234 to word 3
    run_txn("pre3", 1'b0, 1'b1, 3'd3, 16'h0033, 16'h0000);
    reqA = 1'b1; weA = 1'b1; addrA = 3'd3; dinA = 16'h1234;
    tick();
    chk("rstacc.wr_before", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    reqA = 1'b0;
    #1;
    chk("rstacc.wr_gated", {31'd0, mem_write}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rstacc.busy", {31'd0, busy}, 32'd0);
    chk("rstacc.ackA", {31'd0, ackA}, 32'd0);
    tick();
    chk("rstacc.ackA2", {31'd0, ackA}, 32'd0);
    chk("rstacc.mem3", {16'd0, mem[3]}, 32'h00000033);

    // reset during DONE suppresses the ack
    reqA = 1'b1; weA = 1'b0; addrA = 3'd3;
    tick();
    tick();
    reset = 1'b1;
    reqA = 1'b0;
    #1;
    chk("rstdone.ackA", {31'd0, ackA}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rstdone.busy", {31'd0, busy}, 32'd0);

    // B drops its request during ACCESS of a write of 00FF to word 7
    reqB = 1'b1; weB = 1'b1; addrB = 3'd7; dinB = 16'h00FF;
    tick();
    chk("drop.acc_we", {31'd0, mem_write}, 32'd1);
    reqB = 1'b0;
    tick();
    chk("drop.ackB", {31'd0, ackB}, 32'd1);
    chk("drop.mem7", {16'd0, mem[7]}, 32'h000000FF);
    tick();
    chk("drop.ackB_off", {31'd0, ackB}, 32'd0);
    tick();
    chk("drop.no_rearb", {31'd0, busy}, 32'd0);

    // read-before-write on word 4
    run_txn("rbw.seed", 1'b0, 1'b1, 3'd4, 16'hAAAA, 16'h0000);
    run_txn("rbw.wr",   1'b0, 1'b1, 3'd4, 16'h5555, 16'hAAAA);
    run_txn("rbw.rd",   1'b0, 1'b0, 3'd4, 16'h0000, 16'h5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
